// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : State encoding and forward-select constants for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : EX-stage operand forward select for one source register.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_w,
    output logic [1:0] o_sel
);

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hardwired to zero, so a write to it never produces a forward.
    assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs_e);
    assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs_e);

    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_m) begin
            o_sel = FWD_MEM;
        end else if (w_hit_w) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline hazard control: stalls, flushes, forwarding
//               and data-memory wait watchdog. HAZARD_PERF_CNT_EN adds
//               event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic       Mem_Read_E,
    input  logic       PCSrc_E,
    input  logic [4:0] Rd_M,
    input  logic       Reg_write_M,
    input  logic       Mem_req_M,
    input  logic       Mem_ready_M,
    input  logic [4:0] Rd_W,
    input  logic       Reg_write_W,
    output logic       Stall_F,
    output logic       Stall_D,
    output logic       Stall_E,
    output logic       Stall_M,
    output logic       Flush_D,
    output logic       Flush_E,
    output logic [1:0] Forward_A_E,
    output logic [1:0] Forward_B_E,
    output logic       Mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Lu_cnt,
    output logic [31:0] Flush_cnt,
    output logic [31:0] Wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t        r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    logic       w_freeze;
    logic       w_lu;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    fwd_sel u_fwd_a (
        .i_rs_e        (Rs1_E),
        .i_rd_m        (Rd_M),
        .i_reg_write_m (Reg_write_M),
        .i_rd_w        (Rd_W),
        .i_reg_write_w (Reg_write_W),
        .o_sel         (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_rs_e        (Rs2_E),
        .i_rd_m        (Rd_M),
        .i_reg_write_m (Reg_write_M),
        .i_rd_w        (Rd_W),
        .i_reg_write_w (Reg_write_W),
        .o_sel         (w_fwd_b)
    );

    assign w_freeze = (r_state == MEM_WAIT) ||
                      ((r_state == RUN) && Mem_req_M && !Mem_ready_M);
    assign w_lu     = Mem_Read_E && (Rd_E != 5'd0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // A frozen pipeline keeps PCSrc_E in ID/EX, so the redirect is taken on release.
    always_comb begin
        Stall_F     = 1'b0;
        Stall_D     = 1'b0;
        Stall_E     = 1'b0;
        Stall_M     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Forward_A_E = FWD_RF;
        Forward_B_E = FWD_RF;
        if (reset) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else begin
            Forward_A_E = w_fwd_a;
            Forward_B_E = w_fwd_b;
            if (w_freeze) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
            end else if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (w_lu) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (Mem_req_M && !Mem_ready_M) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (Mem_ready_M) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_state    <= TIMEOUT;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                TIMEOUT: begin
                    r_state   <= RUN;
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign Mem_err = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_wait_cnt32;

    // Each counter only tracks the action that actually won priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lu_cnt     <= '0;
            r_flush_cnt  <= '0;
            r_wait_cnt32 <= '0;
        end else begin
            if (w_freeze) begin
                if (r_wait_cnt32 != '1) r_wait_cnt32 <= r_wait_cnt32 + 32'd1;
            end else if (PCSrc_E) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
            end else if (w_lu) begin
                if (r_lu_cnt != '1) r_lu_cnt <= r_lu_cnt + 32'd1;
            end
        end
    end

    assign Lu_cnt    = r_lu_cnt;
    assign Flush_cnt = r_flush_cnt;
    assign Wait_cnt  = r_wait_cnt32;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       Mem_Read_E, PCSrc_E, Reg_write_M, Mem_req_M, Mem_ready_M, Reg_write_W;
    logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Mem_err;
    logic [1:0] Forward_A_E, Forward_B_E;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Lu_cnt, Flush_cnt, Wait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .Mem_Read_E(Mem_Read_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .Reg_write_M(Reg_write_M),
        .Mem_req_M(Mem_req_M), .Mem_ready_M(Mem_ready_M), .Rd_W(Rd_W), .Reg_write_W(Reg_write_W),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Forward_A_E(Forward_A_E),
        .Forward_B_E(Forward_B_E), .Mem_err(Mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .Lu_cnt(Lu_cnt), .Flush_cnt(Flush_cnt), .Wait_cnt(Wait_cnt)
`endif
    );

    // Output bundle: {Mem_err, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, FwdA, FwdB}
    localparam logic [10:0] E_NONE = 11'b0_0000_00_00_00;
    localparam logic [10:0] E_LU   = 11'b0_1100_01_00_00;
    localparam logic [10:0] E_FL   = 11'b0_0000_11_00_00;
    localparam logic [10:0] E_FRZ  = 11'b0_1111_00_00_00;
    localparam logic [10:0] E_ERR  = 11'b1_0000_00_00_00;

    typedef struct {
        logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic        mem_read_e, pcsrc_e;
        logic [4:0]  rd_m;
        logic        rw_m, req, rdy;
        logic [4:0]  rd_w;
        logic        rw_w;
        logic [10:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e,
                                input logic mem_read_e, pcsrc_e, input logic [4:0] rd_m,
                                input logic rw_m, req, rdy, input logic [4:0] rd_w,
                                input logic rw_w, input logic [10:0] exp);
        vec_t v;
        v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e; v.rd_e = rd_e;
        v.mem_read_e = mem_read_e; v.pcsrc_e = pcsrc_e; v.rd_m = rd_m; v.rw_m = rw_m;
        v.req = req; v.rdy = rdy; v.rd_w = rd_w; v.rw_w = rw_w; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Rs1_D = v.rs1_d; Rs2_D = v.rs2_d; Rs1_E = v.rs1_e; Rs2_E = v.rs2_e; Rd_E = v.rd_e;
        Mem_Read_E = v.mem_read_e; PCSrc_E = v.pcsrc_e; Rd_M = v.rd_m; Reg_write_M = v.rw_m;
        Mem_req_M = v.req; Mem_ready_M = v.rdy; Rd_W = v.rd_w; Reg_write_W = v.rw_w;
    endtask

    task automatic clr();
        drive(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, E_NONE));
    endtask

    task automatic chk(input string nm, input logic [10:0] exp);
        logic [10:0] act;
        act = {Mem_err, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Forward_A_E, Forward_B_E};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #2;
        chk("reset_hold", E_FL);

        // Forwarding/hazard vectors, all evaluated in RUN
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, E_NONE));
        vq.push_back(mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 5'd5, 1, 11'b0_0000_00_10_00));
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 5'd0, 1, E_NONE));
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd7, 0, 0, 0, 5'd7, 1, 11'b0_0000_00_00_01));
        vq.push_back(mk(5'd0, 5'd0, 5'd9, 5'd4, 5'd0, 0, 0, 5'd9, 1, 0, 0, 5'd4, 1, 11'b0_0000_00_10_01));
        vq.push_back(mk(5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd6, 0, E_NONE));
        vq.push_back(mk(5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1, 0, 5'd0, 0, 0, 0, 5'd0, 0, E_LU));
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 5'd0, 0, E_NONE));
        vq.push_back(mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, E_NONE));
        vq.push_back(mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1, 1, 5'd0, 0, 0, 0, 5'd0, 0, E_FL));
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 5'd0, 0, E_FL));
        vq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 5'd0, 0, E_NONE));
        vq.push_back(mk(5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1, 0, 5'd0, 0, 1, 1, 5'd0, 0, E_LU));
        vq.push_back(mk(5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 0, 0, 5'd2, 1, 0, 0, 5'd0, 0, 11'b0_0000_00_10_10));

        @(negedge clk);
        reset = 1'b0;
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("vec%0d", i), vq[i].exp);
        end

        // Load-use bubble followed by the bubble itself (Rd_E = 0)
        @(negedge clk); clr(); Mem_Read_E = 1'b1; Rd_E = 5'd3; Rs2_D = 5'd3;
        #1 chk("lu_cycle", E_LU);
        @(negedge clk); Rd_E = 5'd0;
        #1 chk("lu_after", E_NONE);

        // Memory wait: 3 not-ready cycles then ready; held branch must not flush while frozen
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); clr();
            Mem_req_M = 1'b1; Mem_ready_M = (c == 3); PCSrc_E = (c != 0);
            #1 chk($sformatf("memwait_c%0d", c), E_FRZ);
        end
        @(negedge clk); clr(); PCSrc_E = 1'b1;
        #1 chk("memwait_release_branch", E_FL);
        @(negedge clk); clr();
        #1 chk("memwait_done", E_NONE);

        // Async reset in the middle of MEM_WAIT
        @(negedge clk); clr(); Mem_req_M = 1'b1;
        @(negedge clk);
        #1 chk("pre_async_frz", E_FRZ);
        @(negedge clk); Rs1_E = 5'd5; Rd_M = 5'd5; Reg_write_M = 1'b1;
        #2 reset = 1'b1;
        #1 chk("async_reset", E_FL);
        @(negedge clk); reset = 1'b0; clr();
        #1 chk("after_async_run", E_NONE);

        // Watchdog: ready never rises
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); clr(); Mem_req_M = 1'b1;
            #1 chk($sformatf("wd_stall_c%0d", c), E_FRZ);
        end
        @(negedge clk);
        #1 chk("wd_timeout_nofreeze", {Mem_err, 10'b0000_00_00_00});
        @(negedge clk); clr();
        #1 chk("wd_err_set", E_ERR);
        @(negedge clk); PCSrc_E = 1'b1;
        #1 chk("wd_err_sticky", E_ERR | E_FL);
        @(negedge clk); clr();
        #2 reset = 1'b1;
        #1 chk("wd_err_reset", E_FL);
        @(negedge clk); reset = 1'b0;
        #1 chk("wd_after_reset", E_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage core.
- Sequences the IF/ID, ID/EX and EX/MEM pipeline registers:
  - load-use stalls;
  - branch/jump flushes, driven into the ID/EX register's flush input;
  - a full freeze while data memory is not ready.
- Generates EX-stage forwarding selects.
- Includes a data-memory wait watchdog that raises a sticky error.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before forced release (≥2).
- CNT_W, 5: wait-counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1_D, Rs2_D  in  5  source registers of the instruction in ID.
- Rs1_E, Rs2_E, Rd_E  in  5  register fields held in the ID/EX register.
- Mem_Read_E  in  1  instruction in EX is a load.
- PCSrc_E  in  1  branch taken or jump resolved in EX.
- Rd_M  in  5  destination register in MEM.
- Reg_write_M  in  1  MEM instruction writes the register file.
- Mem_req_M  in  1  MEM instruction accesses data memory.
- Mem_ready_M  in  1  data memory completes the access this cycle.
- Rd_W  in  5  destination register in WB.
- Reg_write_W  in  1  WB instruction writes the register file.
- Stall_F, Stall_D  out  1  hold PC / IF-ID.
- Stall_E, Stall_M  out  1  hold ID-EX / EX-MEM.
- Flush_D, Flush_E  out  1  bubble IF-ID / ID-EX.
- Forward_A_E, Forward_B_E  out  2  ALU operand select: 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- Mem_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, clk-independent):
  - state = RUN, wait counter = 0, Mem_err = 0.
  - While reset is high: all stalls 0, Flush_D = Flush_E = 1, forwards 00.
- FSM states: RUN, MEM_WAIT, TIMEOUT. All outputs other than Mem_err are combinational from state and inputs (zero latency).
- Forwarding, identical logic for A (Rs1_E) and B (Rs2_E), evaluated in every state:
  - 10 if Reg_write_M && Rd_M != 0 && Rd_M == Rs_E;
  - else 01 if Reg_write_W && Rd_W != 0 && Rd_W == Rs_E;
  - else 00.
  - MEM beats WB. x0 is never forwarded.
- Definitions:
  - freeze = (state == MEM_WAIT) || (state == RUN && Mem_req_M && !Mem_ready_M).
  - lu = Mem_read_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D).
- Output priority:
  1. freeze: Stall_F = Stall_D = Stall_E = Stall_M = 1; no flushes. PCSrc_E is held by the frozen ID/EX register and acted on in the release cycle.
  2. PCSrc_E: Flush_D = Flush_E = 1; no stall. The load-use is discarded because the ID instruction is squashed.
  3. lu: Stall_F = Stall_D = 1, Flush_E = 1. Exactly one bubble, since Rd_E of the bubble is 0.
  4. Otherwise: all 0.
- Transitions:
  - RUN → MEM_WAIT when Mem_req_M && !Mem_ready_M; counter := 1.
  - MEM_WAIT → RUN when Mem_ready_M. The pipeline is still frozen that cycle; it advances on the next edge.
  - MEM_WAIT: otherwise counter++. When counter == MEM_TIMEOUT−1 and !Mem_ready_M → TIMEOUT.
  - TIMEOUT: no freeze, one cycle; Mem_err := 1 (sticky until reset); → RUN.
  - An access with Mem_ready_M high in the same cycle as Mem_req_M causes no stall.
- Reset asserted mid-MEM_WAIT aborts immediately to RUN and clears the counter.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds outputs Lu_cnt, Flush_cnt and Wait_cnt (32 bits each).
- Each counts the cycles in which its condition (lu taken, PCSrc_E flush, freeze) is the winning action.
- Counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent.

Decomposition:
- Package hazard_pkg:
  - state encoding: RUN = 2'd0, MEM_WAIT = 2'd1, TIMEOUT = 2'd2;
  - forward-select constants: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module fwd_sel: purely combinational. Inputs are one Rs_E, Rd_M, Reg_write_M, Rd_W and Reg_write_W; output is a 2-bit select. It is instantiated twice.

Test Plan:
- Forwarding:
  - Rs1_E = 5, Rd_M = 5, Reg_write_M = 1, Rd_W = 5, Reg_write_W = 1 → Forward_A_E = 10.
  - Rd_M = 0, Rs1_E = 0 → 00.
- Load-use: Mem_Read_E = 1, Rd_E = 3, Rs2_D = 3 → one cycle of Stall_F = Stall_D = Flush_E = 1. Next cycle (Rd_E = 0) → all 0.
- Branch + load-use: PCSrc_E = 1 with the lu condition true → Flush_D = Flush_E = 1, Stall_F = 0.
- Memory wait: Mem_req_M = 1, Mem_ready_M low for 3 cycles then high → all four stalls = 1 for 4 cycles. Then RUN, Mem_err = 0.
- Watchdog: MEM_TIMEOUT = 4, Mem_ready_M never rises → stalls for 4 cycles, TIMEOUT for 1 cycle, Mem_err = 1 and held. reset → Mem_err = 0.
- Async reset: assert reset mid-MEM_WAIT between clock edges → stalls drop to 0 and Flush_D = Flush_E = 1 immediately. The state is RUN after release.
